// File: rtl/inst_fetch_unit_pkg.sv
// Shared encodings for the instruction fetch unit: FSM states, fault causes
// and the default reset PC.
package inst_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } ifu_state_e;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_ACCESS   = 2'b01;
  localparam logic [1:0] FAULT_MISALIGN = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

  localparam logic [31:0] IFU_RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ifu_wait_timer.sv
// Saturating response-wait counter with synchronous clear; expire_o flags the
// last allowed wait cycle (count == WAIT_TIMEOUT-1).
module ifu_wait_timer #(
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned TW = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [TW-1:0] LAST = TW'(WAIT_TIMEOUT - 1);
  localparam logic [TW-1:0] SAT  = TW'(WAIT_TIMEOUT);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, issues one instruction read at a time, holds the
// fetched {pc, inst} for the core and traps on access/misalign/timeout faults.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = IFU_RESET_PC_DEFAULT,
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid_o,
  input  logic        req_ready_i,
  output logic [31:0] req_addr_o,
  input  logic        rsp_valid_i,
  output logic        rsp_ready_o,
  input  logic [31:0] rsp_data_i,
  input  logic        rsp_err_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  input  logic [31:0] next_pc_i,
  output logic        fault_o,
  output logic [1:0]  fault_cause_o,
  output logic [31:0] fault_pc_o,
  output logic [31:0] fetch_cnt_o,
  output logic [1:0]  state_o
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        tmr_clr, tmr_en, tmr_expire;

  ifu_wait_timer #(
    .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) u_timer (
    .clk_i   (clk),
    .rst_ni  (rst),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .expire_o(tmr_expire)
  );

  // Handshakes: a transfer happens on a clock edge where valid and ready are
  // both high; a valid source holds its payload stable until that edge.
  // All valid/ready outputs decode from state_q only.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cause_d = cause_q;
    fpc_d   = fpc_q;
    cnt_d   = cnt_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    case (state_q)
      ST_REQ: begin
        if (req_ready_i) begin
          state_d = ST_WAIT;
          tmr_clr = 1'b1;
        end
      end
      ST_WAIT: begin
        tmr_en = 1'b1;
        // A response arriving on the expiry cycle still wins over the timeout.
        if (rsp_valid_i) begin
          if (rsp_err_i) begin
            state_d = ST_FAULT;
            cause_d = FAULT_ACCESS;
            fpc_d   = pc_q;
          end else begin
            state_d = ST_HOLD;
            inst_d  = rsp_data_i;
          end
        end else if (tmr_expire) begin
          state_d = ST_FAULT;
          cause_d = FAULT_TIMEOUT;
          fpc_d   = pc_q;
        end
      end
      ST_HOLD: begin
        if (inst_ready_i) begin
          cnt_d = cnt_q + 32'd1;
          if (next_pc_i[1:0] != 2'b00) begin
            state_d = ST_FAULT;
            cause_d = FAULT_MISALIGN;
            fpc_d   = next_pc_i;
          end else begin
            state_d = ST_REQ;
            pc_d    = next_pc_i;
          end
        end
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      cause_q <= FAULT_NONE;
      fpc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cause_q <= cause_d;
      fpc_q   <= fpc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_valid_o   = (state_q == ST_REQ);
  assign rsp_ready_o   = (state_q == ST_WAIT);
  assign inst_valid_o  = (state_q == ST_HOLD);
  assign fault_o       = (state_q == ST_FAULT);
  assign req_addr_o    = pc_q;
  assign pc_o          = pc_q;
  assign inst_o        = inst_q;
  assign fault_cause_o = cause_q;
  assign fault_pc_o    = fpc_q;
  assign fetch_cnt_o   = cnt_q;
  assign state_o       = state_q;

endmodule
